// File: rtl/timer_min.sv
// timer_min
// Minute stage and run-control for the countdown-style timer. Gates the
// seconds counter, accumulates its minute carries, compares the minute
// count against a user-set target and runs a timed alarm on a match.
// Every output is a flop; the next values are formed in one combinational
// block and loaded together on the clock edge.

module timer_min #(
   parameter int MAX_MIN       = 60,
   parameter int ALARM_SECONDS = 10
) (
   input  logic       mclk,
   input  logic       reset,
   input  logic       carry_for_min,
   input  logic       sec_p,
   input  logic       btn_start,
   input  logic       btn_set,
   input  logic       btn_inc,
   output logic       enable,
   output logic [5:0] r_min,
   output logic [5:0] r_target,
   output logic [1:0] mode,
   output logic       alarm,
   output logic       blink,
   output logic       sec_clr
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SET   = 2'd1,
      RUN   = 2'd2,
      ALARM = 2'd3
   } stateT;

   // Highest legal minute value; counters wrap from here back to zero.
   localparam logic [5:0] MinLast   = 6'(MAX_MIN - 1);
   // Alarm counter value at which the timed alarm ends on its own.
   localparam logic [7:0] AlarmLast = 8'(ALARM_SECONDS);

   stateT      r_state;
   stateT      w_stateNext;
   logic [7:0] r_alarmCnt;
   logic [7:0] w_alarmCntNext;
   logic [5:0] w_minInc;
   logic [5:0] w_targetInc;
   logic [5:0] w_minNext;
   logic [5:0] w_targetNext;
   logic       w_blinkNext;
   logic       w_secClrNext;
   logic       w_exit;

   // The mode output is the state register itself, so it is registered.
   assign mode = r_state;

   // Modulo-MAX_MIN increments of the minute count and the target.
   always_comb begin
      w_minInc    = (r_min == MinLast) ? 6'd0 : r_min + 6'd1;
      w_targetInc = (r_target == MinLast) ? 6'd0 : r_target + 6'd1;
   end

   // Next-state and next-output decode; everything holds unless a state acts.
   always_comb begin
      w_stateNext    = r_state;
      w_minNext      = r_min;
      w_targetNext   = r_target;
      w_alarmCntNext = r_alarmCnt;
      w_blinkNext    = blink;
      w_secClrNext   = 1'b0;
      w_exit         = 1'b0;

      case (r_state)
         IDLE: begin
            // Start has priority over entering set mode; carries are ignored.
            if (btn_start) begin
               w_stateNext = RUN;
            end else if (btn_set) begin
               w_stateNext = SET;
            end
         end

         SET: begin
            // An increment arriving with the leave request still counts.
            if (btn_inc) begin
               w_targetNext = w_targetInc;
            end
            if (btn_set) begin
               w_stateNext = IDLE;
            end
         end

         RUN: begin
            // The carry is applied before deciding between alarm and pause,
            // so a target match beats a simultaneous pause request.
            if (carry_for_min) begin
               w_minNext = w_minInc;
               if ((w_minInc == r_target) && (r_target != 6'd0)) begin
                  w_stateNext    = ALARM;
                  w_alarmCntNext = 8'd0;
                  w_blinkNext    = 1'b0;
               end else if (btn_start) begin
                  w_stateNext = IDLE;
               end
            end else if (btn_start) begin
               w_stateNext = IDLE;
            end
         end

         ALARM: begin
            // Acknowledge wins over a same-cycle second tick, whose toggle
            // is then dropped.
            if (btn_start) begin
               w_exit = 1'b1;
            end else if (sec_p) begin
               w_alarmCntNext = r_alarmCnt + 8'd1;
               w_blinkNext    = ~blink;
               if (w_alarmCntNext == AlarmLast) begin
                  w_exit = 1'b1;
               end
            end
            if (w_exit) begin
               w_stateNext    = IDLE;
               w_minNext      = 6'd0;
               w_blinkNext    = 1'b0;
               w_alarmCntNext = 8'd0;
               w_secClrNext   = 1'b1;
            end
         end

         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // State and output registers, cleared asynchronously by reset.
   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_min      <= 6'd0;
         r_target   <= 6'd0;
         r_alarmCnt <= 8'd0;
         enable     <= 1'b0;
         alarm      <= 1'b0;
         blink      <= 1'b0;
         sec_clr    <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_min      <= w_minNext;
         r_target   <= w_targetNext;
         r_alarmCnt <= w_alarmCntNext;
         enable     <= (w_stateNext == RUN);
         alarm      <= (w_stateNext == ALARM);
         blink      <= w_blinkNext;
         sec_clr    <= w_secClrNext;
      end
   end

endmodule

// File: doc/timer_min.md
# timer_min

Minute stage and run-control for the countdown-style timer. It sits directly downstream of the seconds counter and does three things: it gates that counter through `enable`, accumulates its `carry_for_min` pulses into a minute count, and compares that count against a user-set target minute. On a match it raises a timed alarm whose duration is measured in the seconds stage's `sec_p` ticks, then clears both stages for the next run.

## Interface
- `MAX_MIN`, default 60: minute modulus; `r_min` and `r_target` wrap from MAX_MIN-1 to 0; legal range 2..64.
- `ALARM_SECONDS`, default 10: alarm duration in `sec_p` pulses; legal range 1..255.

- `mclk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `carry_for_min`  in  1  one-cycle pulse from the seconds stage on the 59→0 wrap.
- `sec_p`  in  1  one-cycle pulse from the seconds stage, once per second, regardless of enable.
- `btn_start`  in  1  debounced one-cycle pulse; start/pause/acknowledge.
- `btn_set`  in  1  debounced one-cycle pulse; enter/leave set mode.
- `btn_inc`  in  1  debounced one-cycle pulse; increment the target in set mode.
- `enable`  out  1  drives the seconds stage `enable`; high only in RUN.
- `r_min`  out  6  elapsed minutes.
- `r_target`  out  6  alarm minute; 0 means no alarm.
- `mode`  out  2  state code: IDLE=0, SET=1, RUN=2, ALARM=3.
- `alarm`  out  1  high throughout ALARM.
- `blink`  out  1  toggles on each `sec_p` in ALARM; 0 otherwise.
- `sec_clr`  out  1  one-cycle pulse, ORed externally into the seconds stage reset.

## Operation
- All outputs are registered.
- Reset values: state IDLE, `r_min`=0, `r_target`=0, `enable`=0, `mode`=0, `alarm`=0, `blink`=0, `sec_clr`=0, alarm counter=0.
- Reset asserted mid-operation returns every register to its reset value asynchronously.
- **IDLE**
  - `btn_start` → RUN.
  - Otherwise `btn_set` → SET.
  - Both asserted in the same cycle: `btn_start` wins.
  - `carry_for_min` is ignored.
- **SET**
  - `btn_inc` sets `r_target` to (`r_target`+1) mod MAX_MIN.
  - `btn_set` → IDLE.
  - `btn_start` is ignored.
  - `btn_inc` and `btn_set` in the same cycle: the increment is applied, then the block returns to IDLE.
- **RUN**
  - `carry_for_min` sets `r_min` to (`r_min`+1) mod MAX_MIN.
  - If the new `r_min` equals `r_target` and `r_target`≠0 → ALARM; the alarm counter loads 0 and `blink` loads 0.
  - Otherwise `btn_start` → IDLE (pause); `r_min` is kept.
  - Carry and `btn_start` in the same cycle: the increment is applied first. A target match takes ALARM over the pause; with no match the block pauses.
  - `btn_set` is ignored.
- **ALARM**
  - Each `sec_p` toggles `blink` and increments the alarm counter.
  - When the counter reaches ALARM_SECONDS, or on `btn_start`, the block exits. On exit: `r_min`←0, `blink`←0, `sec_clr` pulses for one cycle, state → IDLE.
  - `sec_p` and `btn_start` in the same cycle: exit immediately; the toggle is discarded.
  - `r_target` is kept across ALARM so the same alarm can be re-run.
- **Widths and outputs**
  - `r_min` and `r_target` are 6 bits; bits above the range of MAX_MIN-1 read 0.
  - The alarm counter is 8 bits.
  - `enable` = (next state == RUN), registered.
  - `alarm` = (next state == ALARM), registered.
  - `mode` = registered state code.

## Timing
- Latency is one cycle from an input pulse to the updated state, `mode`, `enable`, `r_min` and `r_target`.
- `enable` rises on the edge after `btn_start` is sampled in IDLE, and falls on the edge after the pause or target-match event.
- `sec_clr` is high for exactly the one cycle after the exit edge, coincident with `mode`=0.
- Max rate is one input event per cycle; back-to-back `btn_inc` pulses each count.
- `carry_for_min` seen outside RUN has no effect. This is legal because the seconds stage only carries while enabled, apart from the one-cycle pipeline slip at a pause.

## Test plan
- **Reset**: reset asserted mid-RUN with `r_min`=5 → all outputs 0 immediately, without waiting for a clock edge; `mode`=0 after release.
- **Set-mode wrap**: IDLE, `btn_set`, 61×`btn_inc`, `btn_set` → `r_target`=1, `mode`=0; `btn_start` in SET leaves `mode`=1.
- **Count to alarm**: `r_target`=3, `btn_start`, 3 `carry_for_min` pulses → `r_min`=3, `mode`=3, `alarm`=1 and `enable`=0 one cycle after the 3rd carry.
- **Timed alarm exit**: in ALARM with ALARM_SECONDS=10, 10 `sec_p` pulses → `blink` pattern 1,0,1,…,0. On the 10th pulse: `mode`=0, `r_min`=0, `sec_clr`=1 for one cycle, `r_target`=3 kept.
- **Simultaneous events in RUN**: `r_target`=2, `r_min`=1, carry+`btn_start` in the same cycle → ALARM, not IDLE. Repeat with `r_target`=0 → IDLE with `r_min`=2.
- **Acknowledge during alarm**: `btn_start` together with `sec_p` in ALARM → IDLE next cycle, `blink`=0, single `sec_clr` pulse.
